// File: rtl/key_cmd_pkg.sv
// Shared constants for the keyboard command decoder: HID keycodes, command bit
// positions, repeat-tracker states and the Konami sequence.
package key_cmd_pkg;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_X     = 8'h1B;
  localparam logic [7:0] HID_Z     = 8'h1D;
  localparam logic [7:0] HID_C     = 8'h06;
  localparam logic [7:0] HID_B     = 8'h05;
  localparam logic [7:0] HID_A     = 8'h04;

  localparam int CMD_W      = 9;
  localparam int CMD_LEFT   = 0;
  localparam int CMD_RIGHT  = 1;
  localparam int CMD_SOFT   = 2;
  localparam int CMD_HARD   = 3;
  localparam int CMD_CW     = 4;
  localparam int CMD_CCW    = 5;
  localparam int CMD_HOLD   = 6;
  localparam int CMD_KONAMI = 7;
  localparam int CMD_ANY    = 8;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HELD,
    RPT_REPEAT
  } rpt_state_e;

  localparam int KONAMI_LEN = 10;
  localparam logic [7:0] KONAMI_SEQ [KONAMI_LEN] = '{
    HID_UP, HID_UP, HID_DOWN, HID_DOWN, HID_LEFT,
    HID_RIGHT, HID_LEFT, HID_RIGHT, HID_B, HID_A
  };

  // Game command bit for a keycode; unmapped codes give no command bit.
  function automatic logic [CMD_W-1:0] key_to_cmd(input logic [7:0] kc);
    logic [CMD_W-1:0] c;
    c = '0;
    case (kc)
      HID_LEFT:  c[CMD_LEFT]  = 1'b1;
      HID_RIGHT: c[CMD_RIGHT] = 1'b1;
      HID_DOWN:  c[CMD_SOFT]  = 1'b1;
      HID_SPACE: c[CMD_HARD]  = 1'b1;
      HID_X:     c[CMD_CW]    = 1'b1;
      HID_Z:     c[CMD_CCW]   = 1'b1;
      HID_C:     c[CMD_HOLD]  = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

  function automatic logic is_repeatable(input logic [7:0] kc);
    return (kc == HID_LEFT) || (kc == HID_RIGHT) || (kc == HID_DOWN);
  endfunction

endpackage

// File: rtl/key_cmd_decoder_konami.sv
// Konami sequence tracker: advances on press events and pulses done in the
// same cycle as the final matching press.
module konami_seq
  import key_cmd_pkg::*;
(
  input  logic       Clk,
  input  logic       RESET_N,
  input  logic       press,
  input  logic [7:0] kc,
  output logic       done
);

  logic [3:0] idx_q;
  logic [3:0] idx_d;
  logic       match;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    done  = 1'b0;
    match = (kc == KONAMI_SEQ[idx_q]);
    if (press) begin
      if (match) begin
        if (idx_q == 4'(KONAMI_LEN - 1)) begin
          done  = 1'b1;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else if (kc == HID_UP && idx_q == 4'd2) begin
        idx_d = 4'd2;
      end else if (kc == HID_UP) begin
        idx_d = 4'd1;
      end else begin
        idx_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge Clk) begin
    if (!RESET_N) idx_q <= '0;
    else          idx_q <= idx_d;
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// HID keycode to one-hot game command decoder with DAS/ARR auto-repeat and a
// one-deep acknowledged output register. Optional Konami detection: KONAMI_EN.
module key_cmd_decoder
  import key_cmd_pkg::*;
#(
  parameter int DAS_DELAY  = 10_000_000,
  parameter int ARR_PERIOD = 2_500_000
) (
  input  logic             Clk,
  input  logic             RESET_N,
  input  logic [7:0]       keycode,
  input  logic             cmd_ack,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid
);

  localparam int CNT_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

  logic [7:0]       kc_q;
  logic [7:0]       kc_prev;
  logic             press;
  rpt_state_e       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rpt_ev;
  logic             ev;
  logic [CMD_W-1:0] ev_cmd;
  logic [CMD_W-1:0] konami_cmd;
  logic [CMD_W-1:0] pend_cmd;
  logic             out_free;

  always_ff @(posedge Clk) begin
    if (!RESET_N) begin
      kc_q    <= '0;
      kc_prev <= '0;
    end else begin
      kc_q    <= keycode;
      kc_prev <= kc_q;
    end
  end

  assign press = (kc_q != HID_NONE) && (kc_q != kc_prev);

  // Repeat tracker: non-repeatable keys park in HELD with a saturated counter.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rpt_ev = 1'b0;
    if (press) begin
      st_d  = RPT_HELD;
      cnt_d = '0;
    end else if (kc_q == HID_NONE) begin
      st_d  = RPT_IDLE;
      cnt_d = '0;
    end else begin
      case (st_q)
        RPT_HELD: begin
          if (cnt_q == DAS_LAST) begin
            if (is_repeatable(kc_q)) begin
              st_d   = RPT_REPEAT;
              cnt_d  = '0;
              rpt_ev = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == ARR_LAST) begin
            cnt_d  = '0;
            rpt_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!RESET_N) begin
      st_q  <= RPT_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_free = !cmd_valid || cmd_ack;

`ifdef KONAMI_EN
  logic konami_done;
  logic sticky_q;

  konami_seq u_konami (
    .Clk     (Clk),
    .RESET_N (RESET_N),
    .press   (press),
    .kc      (kc_q),
    .done    (konami_done)
  );

  // A Konami completion that cannot be loaded now is remembered until the
  // output register frees up.
  always_ff @(posedge Clk) begin
    if (!RESET_N)         sticky_q <= 1'b0;
    else if (out_free)    sticky_q <= 1'b0;
    else if (konami_done) sticky_q <= 1'b1;
  end

  assign konami_cmd = konami_done ? CMD_W'(1 << CMD_KONAMI) : '0;
  assign pend_cmd   = sticky_q    ? CMD_W'(1 << CMD_KONAMI) : '0;
`else
  assign konami_cmd = '0;
  assign pend_cmd   = '0;
`endif

  always_comb begin
    ev     = 1'b0;
    ev_cmd = '0;
    if (press) begin
      ev              = 1'b1;
      ev_cmd          = key_to_cmd(kc_q) | konami_cmd;
      ev_cmd[CMD_ANY] = 1'b1;
    end else if (rpt_ev) begin
      ev     = 1'b1;
      ev_cmd = key_to_cmd(kc_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (!RESET_N) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
    end else if (out_free && (ev || pend_cmd != '0)) begin
      cmd       <= ev_cmd | pend_cmd;
      cmd_valid <= 1'b1;
    end else if (cmd_ack && cmd_valid) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
    end
  end

endmodule

// File: doc/key_cmd_decoder.md
# key_cmd_decoder

Converts the raw USB HID keycode from the keyboard interface into one-hot game commands for the Tetris control state machine. It detects key presses and applies auto-repeat (DAS/ARR) to movement keys. It also recognises the Konami sequence. Each command is held in a one-deep output register until the control state machine acknowledges it. The block sits directly upstream of the game control FSM and drives its 9-bit keyboard input.

## Interface
- DAS_DELAY, 10_000_000: cycles a repeatable key must be held before the first repeat
- ARR_PERIOD, 2_500_000: cycles between subsequent repeats
- Clk  in  1  system clock; all logic on rising edge
- RESET_N  in  1  reset, synchronous and active-low
- keycode  in  8  current USB HID keycode; 0x00 = no key
- cmd_ack  in  1  FSM has consumed cmd this cycle
- cmd  out  9  one-hot command, held while cmd_valid
- cmd_valid  out  1  cmd holds an unconsumed command

## Operation
- Key map (HID → cmd bit):
  - 0x50 Left → 0
  - 0x4F Right → 1
  - 0x51 Down (soft drop) → 2
  - 0x2C Space (hard drop) → 3
  - 0x1B X (rotate CW) → 4
  - 0x1D Z (rotate CCW) → 5
  - 0x06 C (hold) → 6
- Bit 7 = Konami complete. Bit 8 = any-key. Bit 8 is set alongside every press event, including unmapped codes.
- Input stage: keycode registered once into kc_q; kc_prev holds the previous kc_q.
- Press event: kc_q ≠ 0 and kc_q ≠ kc_prev. A release (kc_q = 0) is not an event.
- Repeat tracker FSM, one per block, following the current key:
  - IDLE: no key held.
  - HELD: counter counts to DAS_DELAY.
  - REPEAT: counter counts to ARR_PERIOD.
  - Any press event goes to HELD with counter cleared.
  - kc_q = 0 goes to IDLE.
  - HELD goes to REPEAT and emits a repeat event when the counter reaches DAS_DELAY−1.
  - In REPEAT, a repeat event is emitted each time the counter reaches ARR_PERIOD−1, and the counter wraps to 0.
  - Only Left, Right and Down repeat. Other keys stay in HELD and their counter saturates.
  - A repeat event carries the mapped bit only; bit 8 is not set.
- Counter width is $clog2(max(DAS_DELAY, ARR_PERIOD)). Counters never wrap past their terminal value.
- Output register rules:
  - An event loads cmd and sets cmd_valid if cmd_valid = 0, or if cmd_ack = 1 in the same cycle. Ack plus a new event means the new event is loaded.
  - An event arriving while cmd_valid = 1 and cmd_ack = 0 is dropped. The Konami bit is the exception: it is kept in a sticky flag and loaded with the next accepted event, or alone once the register frees.
  - cmd_ack with no new event clears cmd_valid and cmd to 0.
  - cmd_ack while cmd_valid = 0 is ignored.

## Timing
- Reset values: cmd = 0, cmd_valid = 0, kc_q = kc_prev = 0, FSM = IDLE, counters = 0, Konami index = 0, sticky flag = 0.
- Latency: keycode change at edge N appears as cmd_valid high after edge N+2.
- First repeat: DAS_DELAY cycles after the press event. Later repeats every ARR_PERIOD cycles.
- Key switch without release (e.g. Left→Right) is a new press event and restarts DAS.
- RESET_N low mid-hold or mid-sequence: everything returns to reset values next edge. A key still held after reset is seen as a fresh press event.

## Configuration
- Macro KONAMI_EN.
- Defined: konami_seq is instantiated.
  - It advances on press events through Up, Up, Down, Down, Left, Right, Left, Right, B(0x05), A(0x04). Up is 0x52.
  - On mismatch: index stays 2 if the press is Up and index = 2. Otherwise index becomes 1 if the press is Up, else 0.
  - On the tenth match it emits bit 7 together with that press's bit 8, and the index resets to 0.
- Undefined: bit 7 is tied 0, there is no sticky flag, and no sub-module.

## Structure
- Package key_cmd_pkg holds:
  - HID keycode localparams
  - cmd bit index localparams (CMD_LEFT … CMD_ANY)
  - repeat-FSM enum
  - Konami sequence constant array (10 × 8 bits)
- Sub-module konami_seq (press event + keycode in, done pulse out), present under KONAMI_EN only.

## Test plan
- Tap test: keycode 0x1B held 3 cycles, then 0x00 → cmd = 9'h110, cmd_valid after 2 edges. cmd holds until cmd_ack, then reads 0.
- DAS/ARR test: DAS_DELAY = 8, ARR_PERIOD = 4, hold 0x50 for 20 cycles with cmd_ack tied 1 → one 9'h101 event, then 9'h001 at +8, +12, +16.
- Non-repeat key: hold 0x2C for 50 cycles → exactly one 9'h108 event.
- Backpressure: cmd_ack = 0, press 0x50, release, then press 0x4F → cmd stays 9'h101 and the Right press is dropped. Then assert cmd_ack together with a new 0x06 press → 9'h140 loaded.
- Konami (KONAMI_EN): input U,U,U,D,D,L,R,L,R,B,A, each separated by 0x00 → final event 9'h180. Repeat without KONAMI_EN → 9'h100.
- Reset: RESET_N low for 1 cycle while in REPEAT with cmd_valid = 1 → cmd = 0, cmd_valid = 0, and the repeat cadence restarts from the press.
